data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the 16-bit processor's data port.
- Services word read/write requests driven on mem_read, mem_write, mem_address and data_out.
- Returns read data on the processor's data_in, after a programmable number of wait states.
- Holds the data words in a local register array and signals completion and errors back to the requester.

Parameters:
- ADDR_BITS, 8, number of implemented address bits; memory depth is 2**ADDR_BITS 16-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and access (0 to 15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request, level; requester holds it until mem_ready is seen.
- mem_write  input  1  write request, level; same hold rule as mem_read.
- mem_address  input  16  word address of the request.
- wr_data  input  16  write data; connects to the processor's data_out.
- rd_data  output  16  read data; connects to the processor's data_in.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  error qualifier, valid only while mem_ready=1.
- mem_busy  output  1  high from acceptance until the requester releases the request.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, wait counter 0, rd_data=16'h0000, mem_ready=0, mem_err=0, mem_busy=0.
- Memory array contents are not affected by reset and are undefined after power-up.
- All outputs are registered.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - At an edge where mem_read=1 or mem_write=1, the block captures mem_address, wr_data and the operation.
  - Same edge: mem_busy<=1; counter<=WAIT_CYCLES.
  - Next state is WAIT, or ACCESS if WAIT_CYCLES=0.
  - With no request, stay in IDLE.
- WAIT: counter decrements each edge; moves to ACCESS at the edge where the counter reaches 0.
  - Inputs are ignored while in WAIT; the captured values are used.
- ACCESS (one edge): performs the operation and sets mem_ready<=1; next state DONE.
  - Write: array[addr] <= captured wr_data; rd_data unchanged; mem_err<=0.
  - Read: rd_data <= array[addr]; mem_err<=0.
  - Captured address bits [15:ADDR_BITS] not all zero: no array access; rd_data<=16'h0000; mem_err<=1.
  - Captured mem_read=1 and mem_write=1 together: no access; rd_data unchanged; mem_err<=1.
- DONE:
  - mem_ready and mem_err drop to 0 after exactly one cycle high.
  - Stay in DONE while mem_read or mem_write is high, so a held request is never serviced twice.
  - At the first edge with both low: mem_busy<=0 and next state IDLE.
  - A new request is accepted no earlier than the edge after the return to IDLE.
- Latency:
  - Request accepted at edge T; mem_ready is high during the cycle following edge T+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, that is the cycle after edge T+1.
- rd_data holds its value until the next successful read or an out-of-range error, so the requester may sample it late.
- Reset asserted mid-operation (IDLE..ACCESS): the operation is aborted. A write whose ACCESS edge has not occurred does not modify the array.
- Counter width is 4 bits; WAIT_CYCLES outside 0..15 is illegal.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 16'hBEEF to address 16'h0012: mem_ready pulses one cycle, at edge T+3, with mem_err=0.
  - Release the request, then read 16'h0012: rd_data=16'hBEEF when mem_ready=1, and rd_data stays 16'hBEEF afterwards.
- Held request: keep mem_read=1 for 10 cycles after mem_ready.
  - Exactly one mem_ready pulse; mem_busy stays 1 until mem_read=0, then falls at the next edge.
- Out of range, ADDR_BITS=8: read address 16'h0100.
  - mem_ready=1 with mem_err=1 and rd_data=16'h0000.
  - A write to 16'h0100 leaves array[16'h00] unchanged (verify by reading 16'h0000).
- Conflict: mem_read=1 and mem_write=1 with wr_data=16'h1234 at address 16'h0005 (preloaded 16'h5555).
  - mem_err=1; a subsequent read of 16'h0005 returns 16'h5555.
- Zero wait states, WAIT_CYCLES=0: read accepted at edge T gives mem_ready high in the cycle after edge T+1.
  - Back-to-back read/release/read pairs complete every 4 cycles.
- Reset abort: write 16'hAAAA to 16'h0003 (preloaded 16'h0F0F); pull reset low during WAIT.
  - All outputs go to reset values immediately.
  - After release, a read of 16'h0003 returns 16'h0F0F.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the processor data port and the memory responder.
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        mem_ready;
  logic        mem_err;
  logic        mem_busy;

  // Processor side: issues requests, observes completion.
  modport master (
    output mem_read, mem_write, mem_address, wr_data,
    input  rd_data, mem_ready, mem_err, mem_busy
  );

  // Memory side: services requests.
  modport slave (
    input  mem_read, mem_write, mem_address, wr_data,
    output rd_data, mem_ready, mem_err, mem_busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory responder with programmable wait states,
// range/conflict error reporting and hold-until-release handshake.
module data_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_rd_q, op_wr_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rd_data_q, rd_data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        mem_we, mem_re;
  logic        req, capture, oor, conflict;
  logic [ADDR_BITS-1:0] mem_idx;

  // Storage is deliberately left out of reset so it can map onto block RAM.
  logic [15:0] mem_q [2**ADDR_BITS];

  assign req      = bus.mem_read | bus.mem_write;
  assign capture  = (state_q == S_IDLE) && req;
  assign conflict = op_rd_q & op_wr_q;
  assign mem_idx  = addr_q[ADDR_BITS-1:0];

  // Any set address bit above the implemented range flags an error.
  if (ADDR_BITS < 16) begin : g_oor
    assign oor = |addr_q[15:ADDR_BITS];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // State and wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: wait out the counter, access once, then hold until release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   if (!req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and memory strobes.
  always_comb begin
    ready_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      S_IDLE: if (req) busy_d = 1'b1;
      S_ACCESS: begin
        ready_d = 1'b1;
        if (oor) begin
          err_d     = 1'b1;
          rd_data_d = 16'h0000;
        end else if (conflict) begin
          err_d = 1'b1;
        end else if (op_wr_q) begin
          mem_we = 1'b1;
        end else begin
          mem_re = 1'b1;
        end
      end
      S_DONE: if (!req) busy_d = 1'b0;
      default: ;
    endcase
  end

  // Registered outputs and request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= 16'h0000;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      if (mem_re) rd_data_q <= mem_q[mem_idx];
      else        rd_data_q <= rd_data_d;
      if (capture) begin
        op_rd_q <= bus.mem_read;
        op_wr_q <= bus.mem_write;
        addr_q  <= bus.mem_address;
        wdata_q <= bus.wr_data;
      end
    end
  end

  // Array write port; only the ACCESS edge of a clean write reaches it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= wdata_q;
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;
  assign bus.mem_busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a scoreboard of expected responses.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if if2 ();
  data_mem_responder_if if0 ();

  // sel=0 drives the 2-wait-state DUT, sel=1 the zero-wait DUT.
  bit          sel;
  logic        t_rd, t_wr;
  logic [15:0] t_addr, t_wdata;

  assign if2.mem_read    = t_rd & ~sel;
  assign if2.mem_write   = t_wr & ~sel;
  assign if2.mem_address = t_addr;
  assign if2.wr_data     = t_wdata;
  assign if0.mem_read    = t_rd & sel;
  assign if0.mem_write   = t_wr & sel;
  assign if0.mem_address = t_addr;
  assign if0.wr_data     = t_wdata;

  wire [15:0] c_rd    = sel ? if0.rd_data   : if2.rd_data;
  wire        c_ready = sel ? if0.mem_ready : if2.mem_ready;
  wire        c_err   = sel ? if0.mem_err   : if2.mem_err;
  wire        c_busy  = sel ? if0.mem_busy  : if2.mem_busy;

  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [15:0] model [int];
  logic [15:0] last_rd [2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one access; pushes the expected response.
  task automatic expect_op(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data);
    exp_t e;
    int key;
    key = int'(sel) * 65536 + int'(addr);
    if (addr[15:8] != 8'h00) begin
      e.rd = 16'h0000; e.err = 1'b1;
    end else if (rd && wr) begin
      e.rd = last_rd[sel]; e.err = 1'b1;
    end else if (wr) begin
      e.rd = last_rd[sel]; e.err = 1'b0;
      model[key] = data;
    end else begin
      e.rd = model[key]; e.err = 1'b0;
    end
    last_rd[sel] = e.rd;
    sb.push_back(e);
  endtask

  // One full transaction: request, await completion, optional hold, release.
  task automatic op(input logic rd, input logic wr, input logic [15:0] addr,
                    input logic [15:0] data, input int hold, input string tag);
    int n, t, pulses;
    exp_t e;
    @(negedge clk);
    t_rd = rd; t_wr = wr; t_addr = addr; t_wdata = data;
    expect_op(rd, wr, addr, data);
    n = cyc;
    t = 0;
    while (c_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " ready"}, c_ready, 1);
    e = sb.pop_front();
    chk({tag, " rd_data"}, c_rd, e.rd);
    chk({tag, " err"}, c_err, e.err);
    chk({tag, " latency"}, cyc - n, sel ? 2 : 4);
    chk({tag, " busy"}, c_busy, 1);
    @(negedge clk);
    chk({tag, " ready pulse width"}, c_ready, 0);
    chk({tag, " err drop"}, c_err, 0);
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (c_ready) pulses++;
      chk({tag, " busy held"}, c_busy, 1);
    end
    if (hold > 0) chk({tag, " extra pulses"}, pulses, 0);
    t_rd = 1'b0; t_wr = 1'b0;
    @(negedge clk);
    chk({tag, " busy released"}, c_busy, 0);
    chk({tag, " rd_data hold"}, c_rd, last_rd[sel]);
    $display("txn %s: rd=%0b wr=%0b addr=%h wdata=%h -> rd_data=%h err=%0b", tag, rd, wr,
             addr, data, e.rd, e.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, t;
    exp_t e;
    sel = 1'b0;
    t_rd = 1'b0; t_wr = 1'b0; t_addr = 16'h0000; t_wdata = 16'h0000;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset rd_data", if2.rd_data, 16'h0000);
    chk("reset ready", if2.mem_ready, 0);
    chk("reset err", if2.mem_err, 0);
    chk("reset busy", if2.mem_busy, 0);
    chk("reset busy z", if0.mem_busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Write then read back with two wait states.
    op(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0, "wr_0012");
    op(1'b1, 1'b0, 16'h0012, 16'h0000, 0, "rd_0012");
    repeat (3) @(negedge clk);
    chk("rd_data sticky", c_rd, 16'hBEEF);

    // Request held long after completion is serviced once.
    op(1'b1, 1'b0, 16'h0012, 16'h0000, 10, "held_rd");

    // Out-of-range accesses.
    op(1'b0, 1'b1, 16'h0000, 16'h1111, 0, "wr_0000");
    op(1'b1, 1'b0, 16'h0100, 16'h0000, 0, "rd_oor");
    op(1'b0, 1'b1, 16'h0100, 16'h9999, 0, "wr_oor");
    op(1'b1, 1'b0, 16'h0000, 16'h0000, 0, "rd_0000");

    // Simultaneous read and write is rejected.
    op(1'b0, 1'b1, 16'h0005, 16'h5555, 0, "wr_0005");
    op(1'b1, 1'b1, 16'h0005, 16'h1234, 0, "conflict");
    op(1'b1, 1'b0, 16'h0005, 16'h0000, 0, "rd_0005");

    // Reset during WAIT aborts a pending write.
    op(1'b0, 1'b1, 16'h0003, 16'h0F0F, 0, "wr_0003");
    @(negedge clk);
    t_wr = 1'b1; t_addr = 16'h0003; t_wdata = 16'hAAAA;
    @(negedge clk);
    chk("abort accepted", c_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort rd_data", c_rd, 16'h0000);
    chk("abort ready", c_ready, 0);
    chk("abort err", c_err, 0);
    chk("abort busy", c_busy, 0);
    t_wr = 1'b0;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    $display("txn abort: write 0003=AAAA aborted by reset in WAIT");
    op(1'b1, 1'b0, 16'h0003, 16'h0000, 0, "rd_0003");

    // Zero wait states: latency and back-to-back throughput.
    @(negedge clk);
    sel = 1'b1;
    op(1'b0, 1'b1, 16'h0010, 16'hC0DE, 0, "z_wr_0010");
    @(negedge clk);
    t_rd = 1'b1; t_addr = 16'h0010;
    n = cyc;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      expect_op(1'b1, 1'b0, 16'h0010, 16'h0000);
      t = 0;
      while (c_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("z_b2b ready", c_ready, 1);
      e = sb.pop_front();
      chk("z_b2b rd_data", c_rd, e.rd);
      chk("z_b2b err", c_err, e.err);
      if (i == 0) chk("z_b2b latency", cyc - n, 2);
      else        chk("z_b2b period", cyc - prev, 4);
      $display("txn z_b2b[%0d]: rd addr=0010 -> rd_data=%h at cycle %0d", i, c_rd, cyc);
      prev = cyc;
      @(posedge clk); #1 t_rd = 1'b0;
      @(posedge clk); #1 t_rd = (i < 2);
    end
    @(negedge clk);
    chk("z_b2b busy released", c_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
